// File: rtl/sub_pkg.sv
// ============================================================================
// sub_pkg : shared state encoding and default width for serial_subtractor
// Revision: 1.0
// ============================================================================
`default_nettype none

package sub_pkg;

    localparam int c_width_default = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

`default_nettype wire

// File: rtl/full_sub.sv
// ============================================================================
// full_sub : 1-bit full subtractor, d = a - b - bin with borrow out
// Revision: 1.0
// ============================================================================
`default_nettype none

module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_ab_x;
    logic w_a_n;
    logic w_ab_xn;
    logic w_t1;
    logic w_t2;

    xor g_x1 (w_ab_x, a, b);
    xor g_x2 (d, w_ab_x, bin);

    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    not g_n1 (w_a_n, a);
    and g_a1 (w_t1, w_a_n, b);
    not g_n2 (w_ab_xn, w_ab_x);
    and g_a2 (w_t2, w_ab_xn, bin);
    or  g_o1 (bout, w_t1, w_t2);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial a - b - bin, one bit per clock, LSB first
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = c_width_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int                c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    sub_state_t         r_state;
    sub_state_t         w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_br;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-2:0]   r_sh;
    logic [WIDTH-1:0]   w_sh_next;
    logic               w_d;
    logic               w_bout;
    logic               w_accept;
    logic               w_last;

    full_sub u_full_sub (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last    = (r_cnt == c_last);
    // Only the upper WIDTH-1 result bits need storage; the final bit is
    // merged in on the same edge that loads diff.
    assign w_sh_next = {w_d, r_sh};
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
            r_sh  <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a  <= r_a >> 1;
            r_b  <= r_b >> 1;
            r_br <= w_bout;
            r_sh <= w_sh_next[WIDTH-1:1];
            if (w_last) begin
                // On the last bit r_a[0]/r_b[0] are the operand sign bits.
                diff <= w_sh_next;
                bout <= w_bout;
                ovf  <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// tb_serial_subtractor : randomized and directed checks of serial_subtractor
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    // Reference: {diff, bout, ovf} from plain arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mbi);
        logic [W:0]   full;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbi};
        d    = full[W-1:0];
        bo   = (int'(ma) < (int'(mb) + int'(mbi)));
        ov   = (ma[W-1] != mb[W-1]) && (d[W-1] != ma[W-1]);
        return {d, bo, ov};
    endfunction

    // Issues one start, scrambles inputs after capture, waits for done.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obi,
                          output int lat, output int nbusy, output logic [W+1:0] res);
        @(negedge clk);
        rst = 1'b0; start = 1'b1; a = oa; b = ob; bin = obi;
        @(posedge clk);
        lat = -1; nbusy = 0; res = '0;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                res = {diff, bout, ovf};
                break;
            end
        end
    endtask

    task automatic test_reset;
        int lat, nbusy;
        logic [W+1:0] res, exp_r;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_tests++; if (diff !== '0) begin n_fail++; $display("FAIL reset_diff: got %h expected 0000", diff); end
        n_tests++; if ({bout, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {bout, ovf}); end
        // Start on the very first edge after reset release.
        run_op(16'h0005, 16'h0003, 1'b0, lat, nbusy, res);
        exp_r = {16'h0002, 1'b0, 1'b0};
        n_tests++; if (lat !== 16) begin n_fail++; $display("FAIL first_latency: got %0d expected 16", lat); end
        n_tests++; if (nbusy !== 15) begin n_fail++; $display("FAIL first_busy_cycles: got %0d expected 15", nbusy); end
        n_tests++; if (res !== exp_r) begin n_fail++; $display("FAIL first_result: got %h expected %h", res, exp_r); end
    endtask

    task automatic test_directed;
        logic [W-1:0] va [4] = '{16'h0000, 16'h8000, 16'h0010, 16'h0000};
        logic [W-1:0] vb [4] = '{16'h0001, 16'h0001, 16'h0005, 16'h0000};
        logic         vi [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W+1:0] ve [4] = '{{16'hFFFF, 2'b10}, {16'h7FFF, 2'b01},
                                 {16'h000A, 2'b00}, {16'hFFFF, 2'b10}};
        int lat, nbusy;
        logic [W+1:0] res;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vi[i], lat, nbusy, res);
            n_tests++; if (lat !== 16) begin n_fail++; $display("FAIL directed%0d_latency: got %0d expected 16", i, lat); end
            n_tests++; if (res !== ve[i]) begin n_fail++; $display("FAIL directed%0d_result: got %h expected %h", i, res, ve[i]); end
        end
    endtask

    task automatic test_start_in_run;
        int ndone = 0, lat = -1;
        logic [W+1:0] res = '0, exp_r;
        exp_r = model(16'h1234, 16'h0F0F, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h0F0F; bin = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 5) begin
                start = 1'b1; a = 16'hFFFF; b = 16'h0001; bin = 1'b1;
            end else begin
                start = 1'b0; a = W'($urandom); b = W'($urandom);
            end
            @(posedge clk); #1;
            if (done) begin ndone++; lat = k; res = {diff, bout, ovf}; end
        end
        n_tests++; if (ndone !== 1) begin n_fail++; $display("FAIL ignore_start_pulses: got %0d expected 1", ndone); end
        n_tests++; if (lat !== 16) begin n_fail++; $display("FAIL ignore_start_latency: got %0d expected 16", lat); end
        n_tests++; if (res !== exp_r) begin n_fail++; $display("FAIL ignore_start_result: got %h expected %h", res, exp_r); end
    endtask

    task automatic test_reset_abort;
        int ndone = 0, lat, nbusy;
        logic [W+1:0] res, exp_r;
        logic [W-1:0] ra, rb;
        logic         ri;
        @(negedge clk);
        start = 1'b1; a = 16'hBEEF; b = 16'h1111; bin = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); start = 1'b0;
            @(posedge clk);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
        n_tests++; if (diff !== '0) begin n_fail++; $display("FAIL abort_diff: got %h expected 0000", diff); end
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        n_tests++; if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
        ra = W'($urandom); rb = W'($urandom); ri = 1'($urandom);
        exp_r = model(ra, rb, ri);
        run_op(ra, rb, ri, lat, nbusy, res);
        n_tests++; if (res !== exp_r) begin n_fail++; $display("FAIL abort_restart_result: got %h expected %h", res, exp_r); end
    endtask

    task automatic test_back_to_back;
        int ndone = 0;
        int edge_at [2] = '{-1, -1};
        logic [W+1:0] got [2];
        logic [W+1:0] e1, e2;
        got[0] = '0; got[1] = '0;
        e1 = model(16'hA5A5, 16'h5A5A, 1'b0);
        e2 = model(16'h0001, 16'h0002, 1'b1);
        @(negedge clk);
        start = 1'b1; a = 16'hA5A5; b = 16'h5A5A; bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; bin = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            if (done) begin
                if (ndone < 2) begin edge_at[ndone] = k; got[ndone] = {diff, bout, ovf}; end
                ndone++;
            end
            if (k == 17) begin
                n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap_busy: got %b expected 1", busy); end
                start = 1'b0;
            end
            if (k == 20) begin
                n_tests++; if ({diff, bout, ovf} !== e1) begin n_fail++; $display("FAIL b2b_hold_result: got %h expected %h", {diff, bout, ovf}, e1); end
            end
        end
        // The DONE cycle is also the accepting edge of the next operation.
        n_tests++; if (ndone !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", ndone); end
        n_tests++; if (edge_at[0] !== 16) begin n_fail++; $display("FAIL b2b_first_edge: got %0d expected 16", edge_at[0]); end
        n_tests++; if (edge_at[1] !== 33) begin n_fail++; $display("FAIL b2b_second_edge: got %0d expected 33", edge_at[1]); end
        n_tests++; if (got[0] !== e1) begin n_fail++; $display("FAIL b2b_result1: got %h expected %h", got[0], e1); end
        n_tests++; if (got[1] !== e2) begin n_fail++; $display("FAIL b2b_result2: got %h expected %h", got[1], e2); end
    endtask

    task automatic test_random;
        int lat, nbusy;
        logic [W+1:0] res, exp_r;
        logic [W-1:0] ra, rb;
        logic         ri;
        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom); rb = W'($urandom); ri = 1'($urandom);
            if (i == 0) begin ra = 16'h7FFF; rb = 16'hFFFF; ri = 1'b1; end
            if (i == 1) begin ra = 16'h8000; rb = 16'h7FFF; ri = 1'b0; end
            exp_r = model(ra, rb, ri);
            run_op(ra, rb, ri, lat, nbusy, res);
            n_tests++; if (lat !== 16) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected 16", i, lat); end
            n_tests++; if (res !== exp_r) begin n_fail++; $display("FAIL rand%0d_result a=%h b=%h bin=%b: got %h expected %h", i, ra, rb, ri, res, exp_r); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        test_reset;
        test_directed;
        test_start_in_run;
        test_reset_abort;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
